instruction_fetch: RTL

//  - Program-counter and fetch stage directly upstream of instruction_mem.
//  - Drives instruction_address and captures the combinational instruction_data.
//  - Presents each instruction, with its PC, to decode over a valid/ready handshake.
//  - Handles branch redirects, halt opcode, wrap at program end and out-of-range targets.

---
 rtl/instruction_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Brief    : PC/fetch stage feeding decode over valid/ready; handles branch
//            redirects, halt opcode, program-end wrap and out-of-range targets.
//            Optional macro FETCH_COUNT_EN adds a saturating delivered counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
    parameter int                      ADDR_WIDTH  = 8,
    parameter int                      DATA_WIDTH  = 8,
    parameter int                      PROG_LEN    = 6,
    parameter int                      RESET_PC    = 0,
    parameter logic [DATA_WIDTH-1:0]   HALT_OPCODE = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    input  logic [DATA_WIDTH-1:0] instruction_data,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  halted,
    output logic                  fetch_fault
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]           fetch_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] c_PROG_LEN = ADDR_WIDTH'(PROG_LEN);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_PC  = ADDR_WIDTH'(PROG_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] c_RESET_PC = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [DATA_WIDTH-1:0]   r_instr;
    logic [ADDR_WIDTH-1:0]   r_instr_pc;
    logic                    r_valid;
    logic                    r_fault;
    logic                    w_branch;
    logic                    w_load;
    logic                    w_accept;

    // Branches are ignored while idle and always win over load/accept.
    assign w_branch = branch_taken && (r_state != S_IDLE);
    assign w_load   = (r_state == S_RUN) && (!r_valid || instr_ready) && !branch_taken;
    assign w_accept = r_valid && instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_RUN;
            S_RUN:    if (!branch_taken && w_load && (instruction_data == HALT_OPCODE))
                          w_state_nxt = S_HALTED;
            S_HALTED: if (branch_taken) w_state_nxt = S_RUN;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= c_RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
        end else if (w_branch) begin
            r_valid <= 1'b0;
            if (branch_target < c_PROG_LEN) begin
                r_pc <= branch_target;
            end else begin
                r_pc    <= c_RESET_PC;
                r_fault <= 1'b1;
            end
        end else if (w_load) begin
            r_instr    <= instruction_data;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= (r_pc == c_LAST_PC) ? '0 : r_pc + 1'b1;
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign fetch_count = r_count;
`endif

    assign instruction_address = r_pc;
    assign instr_out           = r_instr;
    assign instr_pc            = r_instr_pc;
    assign instr_valid         = r_valid;
    assign halted              = (r_state == S_HALTED);
    assign fetch_fault         = r_fault;

endmodule

`default_nettype wire
